// File: rtl/leb128_if.sv
// Handshake bundle between the code-ROM byte window, the LEB128 decoder and the execute stage.
interface leb128_if;
  logic        start;
  logic        is_signed;
  logic        is_64;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_value;
  logic [3:0]  out_len;
  logic        out_error;

  modport master (
    output start, is_signed, is_64, in_valid, in_byte, out_ready,
    input  in_ready, out_valid, out_value, out_len, out_error
  );

  modport slave (
    input  start, is_signed, is_64, in_valid, in_byte, out_ready,
    output in_ready, out_valid, out_value, out_len, out_error
  );
endinterface

// File: rtl/leb128_decoder.sv
// Sequential LEB128 immediate decoder: one code byte per cycle, signed/unsigned,
// 32/64-bit, reporting value, encoded length and a malformed-encoding flag.
module leb128_decoder #(
  parameter int unsigned MAX_BYTES = 10
) (
  input  logic     clk,
  input  logic     reset,
  leb128_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        signed_q, signed_d;
  logic        is64_q, is64_d;
  logic [63:0] acc_q, acc_d;
  logic [3:0]  count_q, count_d;
  logic [6:0]  shift_q, shift_d;
  logic [63:0] value_q, value_d;
  logic [3:0]  len_q, len_d;
  logic        error_q, error_d;

  logic [63:0] acc_n, ext_value;
  logic [3:0]  count_n, limit;
  logic [6:0]  shift_n;
  logic        at_limit, final_ok, bad, last;

  always_comb begin
    limit    = is64_q ? 4'(MAX_BYTES) : 4'd5;
    count_n  = count_q + 4'd1;
    at_limit = (count_n == limit);
    // shift parks once past bit 63 so later payload bits fall off the top
    shift_n  = (shift_q >= 7'd64) ? shift_q : shift_q + 7'd7;
    acc_n    = acc_q | ({57'd0, bus.in_byte[6:0]} << shift_q);

    final_ok = 1'b1;
    if (!is64_q && count_n == 4'd5) begin
      final_ok = signed_q ? (bus.in_byte[6:3] == 4'h0 || bus.in_byte[6:3] == 4'hF)
                          : (bus.in_byte[6:4] == 3'd0);
    end else if (is64_q && count_n == 4'd10) begin
      final_ok = signed_q ? (bus.in_byte[6:0] == 7'h00 || bus.in_byte[6:0] == 7'h7F)
                          : (bus.in_byte[6:1] == 6'd0);
    end

    last = !bus.in_byte[7] || at_limit;
    bad  = (bus.in_byte[7] && at_limit) || (!bus.in_byte[7] && !final_ok);

    ext_value = acc_n;
    if (signed_q && bus.in_byte[6] && shift_n < 7'd64) begin
      ext_value = acc_n | ({64{1'b1}} << shift_n);
    end
    if (!is64_q) begin
      ext_value[63:32] = signed_q ? {32{ext_value[31]}} : 32'd0;
    end
  end

  always_comb begin
    state_d  = state_q;
    signed_d = signed_q;
    is64_d   = is64_q;
    acc_d    = acc_q;
    count_d  = count_q;
    shift_d  = shift_q;
    value_d  = value_q;
    len_d    = len_q;
    error_d  = error_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = BUSY;
          signed_d = bus.is_signed;
          is64_d   = bus.is_64;
          acc_d    = '0;
          count_d  = '0;
          shift_d  = '0;
        end
      end
      BUSY: begin
        if (bus.in_valid) begin
          acc_d   = acc_n;
          count_d = count_n;
          shift_d = shift_n;
          if (last) begin
            state_d = DONE;
            len_d   = count_n;
            error_d = bad;
            value_d = bad ? '0 : ext_value;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      signed_q <= 1'b0;
      is64_q   <= 1'b0;
      acc_q    <= '0;
      count_q  <= '0;
      shift_q  <= '0;
      value_q  <= '0;
      len_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      signed_q <= signed_d;
      is64_q   <= is64_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      shift_q  <= shift_d;
      value_q  <= value_d;
      len_q    <= len_d;
      error_q  <= error_d;
    end
  end

  assign bus.in_ready  = (state_q == BUSY);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_value = value_q;
  assign bus.out_len   = len_q;
  assign bus.out_error = error_q;
endmodule

// File: doc/leb128_decoder.md
Name: leb128_decoder

Overview:
- Sequential LEB128 immediate decoder between the byte-addressed code ROM window and the CPU execute stage.
- Consumes one code byte per cycle through a valid/ready handshake.
- Accumulates a signed or unsigned, 32- or 64-bit WebAssembly immediate, covering br_table targets, i32/i64.const and memarg fields.
- Returns the decoded value, the encoded length in bytes (so fetch can advance the PC), and a malformed-encoding flag the CPU maps to a trap.

Parameters:
- MAX_BYTES, 10, longest accepted encoding; 64-bit mode limit; 32-bit mode limit is fixed at 5.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  begin a decode; sampled only in IDLE
- is_signed  in  1  sLEB128 when 1, uLEB128 when 0; latched on start
- is_64  in  1  64-bit mode when 1, 32-bit mode when 0; latched on start
- in_valid  in  1  in_byte holds a valid code byte
- in_byte  in  8  code byte from ROM window
- in_ready  out  1  decoder accepts in_byte this cycle
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_value  out  64  decoded value, extended to 64 bits
- out_len  out  4  bytes consumed, 1..10
- out_error  out  1  malformed or over-long encoding

Behaviour:
- States: IDLE, BUSY, DONE. Reset forces IDLE.
- Reset values: in_ready=0, out_valid=0, out_value=0, out_len=0, out_error=0, accumulator=0, byte count=0, shift=0.
- IDLE:
  - in_ready=0.
  - start=1: latch is_signed/is_64, clear accumulator/count/shift, go BUSY next cycle.
  - Bytes arriving in IDLE are not consumed.
- BUSY:
  - in_ready=1.
  - On in_valid&&in_ready: acc |= (in_byte[6:0] << shift); count+=1; shift+=7.
  - shift saturates; bits shifted beyond bit 63 are discarded.
  - Byte with bit7=0 is final: go DONE.
  - Byte with bit7=1 and count==limit (5 for 32-bit, MAX_BYTES for 64-bit): error, go DONE.
  - in_valid=0: hold state, no change.
- Final-byte checks (error if violated):
  - 32-bit unsigned, 5th byte: bits[6:4]==0.
  - 32-bit signed, 5th byte: bits[6:3] all equal.
  - 64-bit unsigned, 10th byte: bits[6:1]==0.
  - 64-bit signed, 10th byte: bits[6:0] all 0 or all 1.
- Extension, applied on DONE entry:
  - Signed: if bit6 of the final byte is 1 and shift<64, fill bits [63:shift] with 1.
  - 32-bit mode: bits [63:32] = sign of bit31 when signed, 0 when unsigned.
- DONE:
  - out_valid=1, in_ready=0.
  - out_value, out_len and out_error are stable while out_valid=1.
  - out_ready=1: return to IDLE next cycle, out_valid=0.
  - start in DONE is ignored.
- Error result: out_error=1, out_len=bytes consumed including the offending byte, out_value=0.
- Latency: first byte is accepted the cycle after start. out_valid rises the cycle after the final byte is accepted. One idle cycle follows each handshake.
- Reset mid-decode (BUSY or DONE): abandon the decode, IDLE on the next edge, all outputs at reset values.
- out_value, out_len and out_error hold their last values in IDLE. They are only meaningful while out_valid=1.

Test Plan:
- Unsigned 32: start(is_signed=0,is_64=0), bytes E5 8E 26 -> out_value=0x0000000000098765 (624485), out_len=3, out_error=0.
- Signed 64: start(1,1), bytes C0 BB 78 -> out_value=0xFFFFFFFFFFFE1DC0 (-123456), out_len=3, out_error=0.
- Signed 32, single byte 7F -> out_value=0xFFFFFFFFFFFFFFFF, out_len=1. Unsigned 32, byte 0C -> out_value=12, out_len=1.
- Limits, unsigned 32:
  - FF FF FF FF 0F -> 0x00000000FFFFFFFF, len 5, no error.
  - FF FF FF FF 1F -> out_error=1, out_value=0, len 5.
  - 80 80 80 80 80 -> out_error=1 after the 5th byte; in_ready=0 after it; a 6th byte is not consumed.
- Backpressure:
  - in_valid gaps mid-decode stretch BUSY with an unchanged result.
  - Holding out_ready=0 for 5 cycles keeps out_valid=1, outputs stable, in_ready=0.
  - start pulses during DONE are ignored.
- Reset: assert reset after 2 bytes of a 3-byte decode -> next cycle IDLE, out_valid=0. A fresh start then decodes 0C -> 12 correctly.
